core_pipe_stage: RTL and testbench
==================================

Name: core_pipe_stage

Overview:
Generic parametrised inter-stage pipeline register for the RV64IM core, superseding the fixed-field, always-enabled stage registers. It carries a payload bus and a separately handled control bus under a valid/ready handshake, with flush and optional skid buffering. It sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB), so hazard and branch logic can stall and squash without per-stage custom registers.

Parameters:
DATA_W, 64, payload width (pc, instr, imm, operands, indices packed by the instantiating stage); must be >= 1
CTRL_W, 16, control-bit width (reg_write, mem_read, mem_write, etc.); must be >= 1
SKID, 0, 0 = single entry with combinational in_ready_o; 1 = two-entry skid buffer with registered in_ready_o

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  squash all held entries and the current input
in_valid_i  input  1  upstream holds a valid instruction
in_ready_o  output  1  stage can accept this cycle
in_data_i  input  DATA_W  upstream payload
in_ctrl_i  input  CTRL_W  upstream control bits
out_valid_o  output  1  stage output holds a valid instruction
out_ready_i  input  1  downstream accepts this cycle (0 = stall)
out_data_o  output  DATA_W  payload of head entry
out_ctrl_o  output  CTRL_W  control of head entry, forced 0 when out_valid_o = 0
occ_o  output  2  entries held (0..1 for SKID=0, 0..2 for SKID=1)

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n; all state clears immediately on assertion.
- Reset values: out_valid_o=0, out_data_o=0, out_ctrl_o=0, occ_o=0. in_ready_o is 1 (SKID=0: combinational; SKID=1: registered, resets to 1).
- Handshakes: accept = in_valid_i & in_ready_o; drain = out_valid_o & out_ready_i. Data and ctrl only change on accept, drain, flush or reset.
- Bubble rule: out_ctrl_o = stored_ctrl & {CTRL_W{out_valid_o}}. An empty or flushed stage never presents a nonzero control bit. Payload is not cleared on drain or flush; it holds its last value.
- Latency: 1 cycle input to output when the stage is empty.
- SKID=0:
  - in_ready_o = ~out_valid_o | out_ready_i.
  - On accept, the main register loads input and valid=1.
  - On drain without accept, valid=0.
  - Drain and accept in the same cycle give full throughput; valid stays 1 and the new data loads.
- SKID=1, with states EMPTY, ONE and TWO:
  - Output is always the main entry.
  - in_ready_o = next_state != TWO, registered.
  - EMPTY: accept -> main<=in, ONE.
  - ONE: accept & drain -> main<=in, stay ONE. Accept & ~drain -> skid<=in, TWO. Drain & ~accept -> EMPTY. Otherwise hold.
  - TWO: in_ready_o=0. Drain -> main<=skid, ONE. Otherwise hold.
  - Order is preserved: the skid entry is always younger than main.
- Flush:
  - flush_i=1 takes priority over every other event that cycle.
  - Next edge: all entries are invalid and occ_o=0, state EMPTY. The input that cycle is discarded even if in_valid_i=1.
  - in_ready_o is forced to 1 during flush, so upstream treats its word as consumed.
  - A drain in the same cycle as flush still counts downstream (the head was presented validly).
- Stall (out_ready_i=0, no flush): the head entry holds bit-exact indefinitely. SKID=0 deasserts in_ready_o. SKID=1 absorbs one more word, then deasserts.
- Reset mid-operation discards all entries with no partial-update hazard; the first accept after deassertion behaves as from EMPTY.
- occ_o mirrors the state: EMPTY=0, ONE=1, TWO=2.

Decomposition:
- Shared package/defines: SKID mode constants (PIPE_SKID_NONE=0, PIPE_SKID_ON=1), state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2), and per-stage DATA_W/CTRL_W widths derived from the existing operand/PC/RF-index width macros.
- One natural sub-module, core_pipe_entry: an async-reset register holding {valid, ctrl, data} with load enable and a synchronous valid clear. Instantiate it once for main, and once more for skid under generate when SKID=1.

Test Plan:
- Reset then stream, SKID=0, out_ready_i=1: feed data 0x1..0x8 with ctrl 0x00FF on consecutive cycles -> each appears exactly 1 cycle later, one word per cycle, occ_o=1 throughout.
- Stall, SKID=0: hold 0xAAAA, drop out_ready_i for 5 cycles with in_valid_i=1 carrying 0xBBBB -> out_data_o stays 0xAAAA and in_ready_o=0 for all 5 cycles. 0xBBBB appears the cycle after out_ready_i returns.
- Skid, SKID=1: stream 0x10,0x11,0x12 and drop out_ready_i while 0x10 is at the output -> 0x11 is captured (occ_o=2) and in_ready_o=0 the next cycle. On release the order is 0x10, 0x11, 0x12 with no loss or duplication.
- Flush in state TWO with a valid input 0x99 and ctrl 0xFFFF -> next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0 and in_ready_o=1. 0x99 never appears at the output.
- Async reset pulse mid-stream, rst_n low for half a cycle between edges -> outputs go to 0 immediately without waiting for a clock edge. The stream resumes cleanly afterwards with 1-cycle latency.
- Bubble check: randomised valid/ready for 10k cycles under both SKID settings -> whenever out_valid_o=0, out_ctrl_o=0. The output sequence equals the accepted-input sequence in order, minus any flushed entries.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// skid mode selectors, occupancy state encoding and per-stage widths.
package core_pipe_pkg;

    localparam int PIPE_SKID_NONE = 0;
    localparam int PIPE_SKID_ON   = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam int XLEN     = 64;
    localparam int PC_W     = 64;
    localparam int INSTR_W  = 32;
    localparam int RF_IDX_W = 5;

    // Payload widths packed by each instantiating stage.
    localparam int IF_ID_DATA_W  = PC_W + INSTR_W;
    localparam int ID_EX_DATA_W  = PC_W + 3 * XLEN + 3 * RF_IDX_W;
    localparam int EX_MEM_DATA_W = 2 * XLEN + RF_IDX_W;
    localparam int MEM_WB_DATA_W = XLEN + RF_IDX_W;
    localparam int PIPE_CTRL_W   = 16;

    function automatic logic [1:0] occ_of_state(input pipe_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/core_pipe_entry.sv
// One pipeline slot: {valid, ctrl, data} with load enable and a synchronous
// valid clear that wins over load. Payload is retained when valid clears.
module core_pipe_entry
    import core_pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d,  data_q;
    logic [CTRL_W-1:0] ctrl_d,  ctrl_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/core_pipe_stage.sv
// Generic valid/ready pipeline register between core stages, with flush and
// an optional two-entry skid buffer that registers in_ready_o.
module core_pipe_stage
    import core_pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int SKID   = PIPE_SKID_NONE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occ_o
);

    logic              main_load;
    logic              main_clr;
    logic              main_valid;
    logic [DATA_W-1:0] main_in_data;
    logic [CTRL_W-1:0] main_in_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              accept;
    logic              drain;

    assign accept = in_valid_i & in_ready_o;
    assign drain  = main_valid & out_ready_i;

    core_pipe_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clr_i   (main_clr),
        .data_i  (main_in_data),
        .ctrl_i  (main_in_ctrl),
        .valid_o (main_valid),
        .data_o  (main_data),
        .ctrl_o  (main_ctrl)
    );

    generate
        if (SKID == PIPE_SKID_ON) begin : g_skid
            pipe_state_e       state_d, state_q;
            logic              in_ready_d, in_ready_q;
            logic              skid_load;
            logic              skid_clr;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            core_pipe_entry #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (skid_load),
                .clr_i   (skid_clr),
                .data_i  (in_data_i),
                .ctrl_i  (in_ctrl_i),
                .valid_o (skid_valid),
                .data_o  (skid_data),
                .ctrl_o  (skid_ctrl)
            );

            // Main refills from the older skid word whenever one is held.
            always_comb begin
                main_in_data = skid_valid ? skid_data : in_data_i;
                main_in_ctrl = skid_valid ? skid_ctrl : in_ctrl_i;
            end

            always_comb begin
                state_d   = state_q;
                main_load = 1'b0;
                main_clr  = 1'b0;
                skid_load = 1'b0;
                skid_clr  = 1'b0;
                if (flush_i) begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (accept) begin
                                main_load = 1'b1;
                                state_d   = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (accept && drain) begin
                                main_load = 1'b1;
                            end else if (accept) begin
                                skid_load = 1'b1;
                                state_d   = ST_TWO;
                            end else if (drain) begin
                                main_clr  = 1'b1;
                                state_d   = ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (drain) begin
                                main_load = 1'b1;
                                skid_clr  = 1'b1;
                                state_d   = ST_ONE;
                            end
                        end
                        default: begin
                            main_clr = 1'b1;
                            skid_clr = 1'b1;
                            state_d  = ST_EMPTY;
                        end
                    endcase
                end
                in_ready_d = (state_d != ST_TWO);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready_o = in_ready_q | flush_i;
            assign occ_o      = occ_of_state(state_q);
        end else begin : g_noskid
            always_comb begin
                main_in_data = in_data_i;
                main_in_ctrl = in_ctrl_i;
                main_load    = accept & ~flush_i;
                main_clr     = flush_i | (drain & ~accept);
            end

            assign in_ready_o = flush_i | ~main_valid | out_ready_i;
            assign occ_o      = {1'b0, main_valid};
        end
    endgenerate

    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;
    assign out_ctrl_o  = main_ctrl & {CTRL_W{main_valid}};

endmodule

// File: tb/tb_core_pipe_stage.sv
// Bench for core_pipe_stage: one SKID=0 and one SKID=1 instance share the
// same stimulus; directed vectors plus a randomised queue-model comparison.
module tb_core_pipe_stage;
    import core_pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          in_ready  [2];
    logic          out_valid [2];
    logic [DW-1:0] out_data  [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [1:0]    occ       [2];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } word_t;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_ctrl;
        logic [1:0]    e_occ;
        logic          e_ready;
    } vec_t;

    vec_t  tbl [$];
    word_t mq0 [$];
    word_t mq1 [$];

    always #5 clk = ~clk;

    core_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(PIPE_SKID_NONE)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .flush_i (flush),
        .in_valid_i (in_valid), .in_ready_o (in_ready[0]),
        .in_data_i (in_data), .in_ctrl_i (in_ctrl),
        .out_valid_o (out_valid[0]), .out_ready_i (out_ready),
        .out_data_o (out_data[0]), .out_ctrl_o (out_ctrl[0]), .occ_o (occ[0])
    );

    core_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(PIPE_SKID_ON)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .flush_i (flush),
        .in_valid_i (in_valid), .in_ready_o (in_ready[1]),
        .in_data_i (in_data), .in_ctrl_i (in_ctrl),
        .out_valid_o (out_valid[1]), .out_ready_i (out_ready),
        .out_data_o (out_data[1]), .out_ctrl_o (out_ctrl[1]), .occ_o (occ[1])
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string tag, input int k, input logic e_valid,
                               input logic [DW-1:0] e_data, input logic [CW-1:0] e_ctrl,
                               input logic [1:0] e_occ, input logic e_ready);
        cmp($sformatf("%s.dut%0d.valid", tag, k), 64'(out_valid[k]), 64'(e_valid));
        cmp($sformatf("%s.dut%0d.data", tag, k), 64'(out_data[k]), 64'(e_data));
        cmp($sformatf("%s.dut%0d.ctrl", tag, k), 64'(out_ctrl[k]), 64'(e_ctrl));
        cmp($sformatf("%s.dut%0d.occ", tag, k), 64'(occ[k]), 64'(e_occ));
        cmp($sformatf("%s.dut%0d.ready", tag, k), 64'(in_ready[k]), 64'(e_ready));
    endtask

    // One directed cycle: drive after the edge, check at the falling edge.
    task automatic step_check(input string tag, input int k, input logic iv, input logic [DW-1:0] d,
                              input logic [CW-1:0] c, input logic ordy, input logic fl,
                              input logic e_valid, input logic [DW-1:0] e_data,
                              input logic [CW-1:0] e_ctrl, input logic [1:0] e_occ,
                              input logic e_ready);
        applyStimulus(iv, d, c, ordy, fl);
        @(negedge clk);
        checkOutput(tag, k, e_valid, e_data, e_ctrl, e_occ, e_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add_vec(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input logic ordy, input logic ev, input logic [DW-1:0] ed,
                           input logic [CW-1:0] ec, input logic [1:0] eo, input logic er);
        vec_t v;
        v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
        v.e_valid = ev; v.e_data = ed; v.e_ctrl = ec; v.e_occ = eo; v.e_ready = er;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

        // Reset state for both variants
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            checkOutput("reset", k, 1'b0, '0, '0, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // SKID=0 stream 1..8 then stall with AAAA held and BBBB waiting
        for (int i = 0; i < 8; i++) begin
            if (i == 0) add_vec(1'b1, 32'd1, 16'h00FF, 1'b1, 1'b0, '0, '0, 2'd0, 1'b1);
            else        add_vec(1'b1, DW'(i + 1), 16'h00FF, 1'b1, 1'b1, DW'(i), 16'h00FF, 2'd1, 1'b1);
        end
        add_vec(1'b0, '0, '0, 1'b1, 1'b1, 32'd8, 16'h00FF, 2'd1, 1'b1);
        add_vec(1'b0, '0, '0, 1'b1, 1'b0, 32'd8, 16'h0000, 2'd0, 1'b1);
        add_vec(1'b1, 32'hAAAA, 16'h1234, 1'b1, 1'b0, 32'd8, 16'h0000, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++)
            add_vec(1'b1, 32'hBBBB, 16'h5678, 1'b0, 1'b1, 32'hAAAA, 16'h1234, 2'd1, 1'b0);
        add_vec(1'b1, 32'hBBBB, 16'h5678, 1'b1, 1'b1, 32'hAAAA, 16'h1234, 2'd1, 1'b1);
        add_vec(1'b0, '0, '0, 1'b1, 1'b1, 32'hBBBB, 16'h5678, 2'd1, 1'b1);
        add_vec(1'b0, '0, '0, 1'b1, 1'b0, 32'hBBBB, 16'h0000, 2'd0, 1'b1);

        foreach (tbl[i])
            step_check($sformatf("vec%0d", i), 0, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, 1'b0,
                       tbl[i].e_valid, tbl[i].e_data, tbl[i].e_ctrl, tbl[i].e_occ, tbl[i].e_ready);

        // SKID=1: stall while 0x10 is at the head, 0x11 goes into the skid slot
        do_reset();
        step_check("skid0", 1, 1'b1, 32'h10, 16'h0F0F, 1'b1, 1'b0, 1'b0, 32'h0,  16'h0000, 2'd0, 1'b1);
        step_check("skid1", 1, 1'b1, 32'h11, 16'h0F0F, 1'b0, 1'b0, 1'b1, 32'h10, 16'h0F0F, 2'd1, 1'b1);
        step_check("skid2", 1, 1'b1, 32'h12, 16'h0F0F, 1'b0, 1'b0, 1'b1, 32'h10, 16'h0F0F, 2'd2, 1'b0);
        step_check("skid3", 1, 1'b1, 32'h12, 16'h0F0F, 1'b1, 1'b0, 1'b1, 32'h10, 16'h0F0F, 2'd2, 1'b0);
        step_check("skid4", 1, 1'b1, 32'h12, 16'h0F0F, 1'b1, 1'b0, 1'b1, 32'h11, 16'h0F0F, 2'd1, 1'b1);
        step_check("skid5", 1, 1'b0, 32'h0,  16'h0000, 1'b1, 1'b0, 1'b1, 32'h12, 16'h0F0F, 2'd1, 1'b1);
        step_check("skid6", 1, 1'b0, 32'h0,  16'h0000, 1'b1, 1'b0, 1'b0, 32'h12, 16'h0000, 2'd0, 1'b1);

        // SKID=1 flush while full, with 0x99 offered in the flush cycle
        step_check("fl0", 1, 1'b1, 32'h20, 16'h1111, 1'b0, 1'b0, 1'b0, 32'h12, 16'h0000, 2'd0, 1'b1);
        step_check("fl1", 1, 1'b1, 32'h21, 16'h1111, 1'b0, 1'b0, 1'b1, 32'h20, 16'h1111, 2'd1, 1'b1);
        step_check("fl2", 1, 1'b1, 32'h99, 16'hFFFF, 1'b0, 1'b1, 1'b1, 32'h20, 16'h1111, 2'd2, 1'b1);
        step_check("fl3", 1, 1'b0, 32'h0,  16'h0000, 1'b1, 1'b0, 1'b0, 32'h20, 16'h0000, 2'd0, 1'b1);
        step_check("fl4", 1, 1'b0, 32'h0,  16'h0000, 1'b1, 1'b0, 1'b0, 32'h20, 16'h0000, 2'd0, 1'b1);

        // Asynchronous reset pulse between edges while both stages hold 0x55
        applyStimulus(1'b1, 32'h55, 16'h00FF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++)
            checkOutput("arst", k, 1'b0, '0, '0, 2'd0, 1'b1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            step_check("resume0", k, 1'b1, 32'h66, 16'h00F0, 1'b1, 1'b0, 1'b0, 32'h0, 16'h0000, 2'd0, 1'b1);
            step_check("resume1", k, 1'b0, 32'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h66, 16'h00F0, 2'd1, 1'b1);
            do_reset();
        end

        // Randomised traffic against an in-order queue model of each variant
        mq0.delete();
        mq1.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic          iv, ordy, fl;
            logic [DW-1:0] d;
            logic [CW-1:0] c;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 49) == 0);
            d    = $urandom;
            c    = 16'($urandom);
            applyStimulus(iv, d, c, ordy, fl);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int    sz;
                word_t head;
                logic  e_ready, drn, acc;
                word_t w;
                sz   = (k == 0) ? mq0.size() : mq1.size();
                head = '{d: '0, c: '0};
                if (sz > 0) head = (k == 0) ? mq0[0] : mq1[0];
                e_ready = (k == 0) ? (fl || sz == 0 || ordy) : (fl || sz < 2);
                cmp($sformatf("rnd%0d.dut%0d.valid", cyc, k), 64'(out_valid[k]), 64'(sz > 0));
                cmp($sformatf("rnd%0d.dut%0d.ctrl", cyc, k), 64'(out_ctrl[k]), 64'(head.c));
                cmp($sformatf("rnd%0d.dut%0d.occ", cyc, k), 64'(occ[k]), 64'(sz));
                cmp($sformatf("rnd%0d.dut%0d.ready", cyc, k), 64'(in_ready[k]), 64'(e_ready));
                if (sz > 0)
                    cmp($sformatf("rnd%0d.dut%0d.data", cyc, k), 64'(out_data[k]), 64'(head.d));
                drn = (sz > 0) && ordy;
                acc = iv && e_ready;
                w.d = d;
                w.c = c;
                if (k == 0) begin
                    if (fl) mq0.delete();
                    else begin
                        if (drn) void'(mq0.pop_front());
                        if (acc) mq0.push_back(w);
                    end
                end else begin
                    if (fl) mq1.delete();
                    else begin
                        if (drn) void'(mq1.pop_front());
                        if (acc) mq1.push_back(w);
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
